// File: rtl/eth_rx_pkg.sv
// Shared types for the RGMII receive path: framing FSM states, framing bytes
// and the in-band link status word carried on RX data between frames.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DROP
    } rx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    typedef enum logic [1:0] {
        SPEED_10M   = 2'b00,
        SPEED_100M  = 2'b01,
        SPEED_1000M = 2'b10
    } link_speed_t;

    typedef struct packed {
        logic        link_up;
        link_speed_t speed;
        logic        full_duplex;
    } link_status_t;

    // Inter-frame nibble layout: bit0 link, bits2:1 speed, bit3 duplex.
    function automatic link_status_t decode_status(input logic [3:0] nib);
        link_status_t s;
        s.link_up     = nib[0];
        s.speed       = link_speed_t'(nib[2:1]);
        s.full_duplex = nib[3];
        return s;
    endfunction

endpackage

// File: rtl/rgmii_rx_frame_if.sv
// Byte-wide receive stream (tdata/tvalid/tlast/tuser), no ready: the source
// never stalls, so a sink must accept one beat per cycle.
interface rgmii_rx_frame_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser);
endinterface

// File: rtl/rgmii_rx_decode.sv
// Rebuilds the RGMII byte from DDR nibbles, splits RX_CTL into dv/er and tracks in-band link status.
// Latency: one cycle for byte/dv/er, two cycles for the status outputs.
// Backpressure: none; free-running every rx_clk.
module rgmii_rx_decode
    import eth_rx_pkg::*;
(
    input  logic         rx_clk,
    input  logic         sys_rst_n,
    input  logic [3:0]   rxd_rise,
    input  logic [3:0]   rxd_fall,
    input  logic         rxctl_rise,
    input  logic         rxctl_fall,
    output logic [7:0]   byte_r,
    output logic         dv_r,
    output logic         er_r,
    output link_status_t status
);

    logic ibs_r;

    always_ff @(posedge rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_r <= '0;
            dv_r   <= 1'b0;
            er_r   <= 1'b0;
            ibs_r  <= 1'b0;
            status <= '0;
        end else begin
            byte_r <= {rxd_fall, rxd_rise};
            dv_r   <= rxctl_rise;
            er_r   <= rxctl_rise ^ rxctl_fall;
            // Status is only carried in normal inter-frame with both nibbles repeated.
            ibs_r  <= !rxctl_rise && !rxctl_fall && (rxd_rise == rxd_fall);
            if (ibs_r) begin
                status <= decode_status(byte_r[3:0]);
            end
        end
    end

endmodule

// File: rtl/rgmii_rx_frame.sv
// RGMII 1000M receive framer: strips preamble/SFD, emits frames as a byte stream with tlast/tuser, counts frames.
// Latency: a byte leaves 2 cycles after the next byte (or the first dv-low) arrives on the pins.
// Backpressure: none; the stream output cannot stall.
module rgmii_rx_frame
    import eth_rx_pkg::*;
#(
    parameter int MIN_PREAMBLE = 2,
    parameter int MAX_LEN      = 1518,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  rx_clk,
    input  logic                  sys_rst_n,
    input  logic [3:0]            rxd_rise,
    input  logic [3:0]            rxd_fall,
    input  logic                  rxctl_rise,
    input  logic                  rxctl_fall,
    rgmii_rx_frame_if.master      m_axis,
    output logic                  link_up,
    output logic [1:0]            link_speed,
    output logic                  full_duplex,
    output logic [CNT_WIDTH-1:0]  frame_ok_cnt,
    output logic [CNT_WIDTH-1:0]  frame_err_cnt
);

    localparam int               LEN_W     = $clog2(MAX_LEN + 2);
    localparam logic [2:0]       MIN_PCNT  = 3'(MIN_PREAMBLE);
    localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN);

    logic [7:0]   byte_r;
    logic         dv_r;
    logic         er_r;
    link_status_t status;

    rgmii_rx_decode u_decode (
        .rx_clk     (rx_clk),
        .sys_rst_n  (sys_rst_n),
        .rxd_rise   (rxd_rise),
        .rxd_fall   (rxd_fall),
        .rxctl_rise (rxctl_rise),
        .rxctl_fall (rxctl_fall),
        .byte_r     (byte_r),
        .dv_r       (dv_r),
        .er_r       (er_r),
        .status     (status)
    );

    assign link_up     = status.link_up;
    assign link_speed  = status.speed;
    assign full_duplex = status.full_duplex;

    rx_state_t        state, state_n;
    logic [2:0]       pcnt, pcnt_n;
    logic [LEN_W-1:0] len, len_n;
    logic             err_seen, err_seen_n;
    logic [7:0]       hold_dat, hold_dat_n;
    logic             hold_full, hold_full_n;
    logic [7:0]       tdata_n;
    logic             tvalid_n, tlast_n, tuser_n;
    logic             ok_inc, err_inc;

    always_comb begin
        state_n     = state;
        pcnt_n      = pcnt;
        len_n       = len;
        err_seen_n  = err_seen;
        hold_dat_n  = hold_dat;
        hold_full_n = hold_full;
        tvalid_n    = 1'b0;
        tlast_n     = 1'b0;
        tuser_n     = 1'b0;
        ok_inc      = 1'b0;
        err_inc     = 1'b0;

        unique case (state)
            IDLE: begin
                if (dv_r) begin
                    if (byte_r == PREAMBLE_BYTE) begin
                        state_n = PREAMBLE;
                        pcnt_n  = 3'd1;
                    end else begin
                        state_n = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!dv_r) begin
                    state_n = IDLE;
                end else if (er_r) begin
                    state_n = DROP;
                end else if (byte_r == PREAMBLE_BYTE) begin
                    pcnt_n = (pcnt == 3'd7) ? 3'd7 : pcnt + 3'd1;
                end else if (byte_r == SFD_BYTE && pcnt >= MIN_PCNT) begin
                    state_n     = PAYLOAD;
                    len_n       = '0;
                    err_seen_n  = 1'b0;
                    hold_full_n = 1'b0;
                end else begin
                    state_n = DROP;
                end
            end
            PAYLOAD: begin
                if (!dv_r) begin
                    // The held byte is the frame's last; an empty hold means SFD then nothing.
                    if (hold_full) begin
                        tvalid_n = 1'b1;
                        tlast_n  = 1'b1;
                        tuser_n  = err_seen;
                        ok_inc   = !err_seen;
                        err_inc  = err_seen;
                    end else begin
                        err_inc = 1'b1;
                    end
                    hold_full_n = 1'b0;
                    state_n     = IDLE;
                end else if (len == LEN_LIMIT) begin
                    // This byte is one past the limit: close out the frame as bad.
                    tvalid_n    = 1'b1;
                    tlast_n     = 1'b1;
                    tuser_n     = 1'b1;
                    err_inc     = 1'b1;
                    hold_full_n = 1'b0;
                    state_n     = DROP;
                end else begin
                    tvalid_n    = hold_full;
                    hold_dat_n  = byte_r;
                    hold_full_n = 1'b1;
                    len_n       = len + LEN_W'(1);
                    err_seen_n  = err_seen | er_r;
                end
            end
            DROP: begin
                if (!dv_r) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        tdata_n = tvalid_n ? hold_dat : 8'h00;
    end

    always_ff @(posedge rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            pcnt          <= '0;
            len           <= '0;
            err_seen      <= 1'b0;
            hold_dat      <= '0;
            hold_full     <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tuser  <= 1'b0;
            frame_ok_cnt  <= '0;
            frame_err_cnt <= '0;
        end else begin
            state         <= state_n;
            pcnt          <= pcnt_n;
            len           <= len_n;
            err_seen      <= err_seen_n;
            hold_dat      <= hold_dat_n;
            hold_full     <= hold_full_n;
            m_axis.tdata  <= tdata_n;
            m_axis.tvalid <= tvalid_n;
            m_axis.tlast  <= tlast_n;
            m_axis.tuser  <= tuser_n;
            if (ok_inc) begin
                frame_ok_cnt <= frame_ok_cnt + CNT_WIDTH'(1);
            end
            if (err_inc) begin
                frame_err_cnt <= frame_err_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_rgmii_rx_frame.sv
// Bench for rgmii_rx_frame: builds a pin-level stimulus script, derives expected outputs from frame-level rules,
// then replays the script and compares the DUT every cycle.
module tb_rgmii_rx_frame;

    localparam int MIN_PRE = 2;
    localparam int MAX_LEN = 1518;
    localparam int CW      = 32;
    localparam int N       = 8192;

    logic          rx_clk     = 1'b0;
    logic          sys_rst_n  = 1'b0;
    logic [3:0]    rxd_rise   = 4'h0;
    logic [3:0]    rxd_fall   = 4'h0;
    logic          rxctl_rise = 1'b0;
    logic          rxctl_fall = 1'b0;
    logic          link_up;
    logic [1:0]    link_speed;
    logic          full_duplex;
    logic [CW-1:0] frame_ok_cnt;
    logic [CW-1:0] frame_err_cnt;

    rgmii_rx_frame_if axis ();

    rgmii_rx_frame #(
        .MIN_PREAMBLE (MIN_PRE),
        .MAX_LEN      (MAX_LEN),
        .CNT_WIDTH    (CW)
    ) dut (
        .rx_clk        (rx_clk),
        .sys_rst_n     (sys_rst_n),
        .rxd_rise      (rxd_rise),
        .rxd_fall      (rxd_fall),
        .rxctl_rise    (rxctl_rise),
        .rxctl_fall    (rxctl_fall),
        .m_axis        (axis),
        .link_up       (link_up),
        .link_speed    (link_speed),
        .full_duplex   (full_duplex),
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    // Stimulus script, one entry per cycle.
    logic [3:0] s_rr [N];
    logic [3:0] s_rf [N];
    bit         s_cr [N];
    bit         s_cf [N];
    bit         s_rst[N];
    bit         s_rel[N];
    int         n_stim = 0;

    // Expected outputs, one entry per sampled cycle.
    bit         e_vld [N];
    bit         e_last[N];
    bit         e_user[N];
    logic [7:0] e_dat [N];
    logic [CW-1:0] e_ok [N];
    logic [CW-1:0] e_err[N];
    logic [3:0] e_st  [N];
    int         ok_inc [N];
    int         err_inc[N];
    bit         rst_win[N];
    bit         no_qual[N];

    typedef struct {
        int cyc;
        int ok;
        int err;
        int beats;
        int st;
    } cp_t;
    cp_t cps[$];

    int checks   = 0;
    int failures = 0;

    function automatic logic [7:0] sbyte(input int c);
        return {s_rf[c], s_rr[c]};
    endfunction

    function automatic bit ser(input int c);
        return s_cr[c] ^ s_cf[c];
    endfunction

    task automatic push(input logic [3:0] rr, input logic [3:0] rf, input bit cr, input bit cf);
        if (n_stim >= N - 8) begin
            $display("FAIL stimulus_overflow actual=%0d required<%0d", n_stim, N - 8);
            $fatal(1);
        end
        s_rr[n_stim] = rr;
        s_rf[n_stim] = rf;
        s_cr[n_stim] = cr;
        s_cf[n_stim] = cf;
        n_stim++;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit er);
        push(b[3:0], b[7:4], 1'b1, ~er);
    endtask

    task automatic idle_fix(input int n, input logic [3:0] rr, input logic [3:0] rf);
        for (int i = 0; i < n; i++) push(rr, rf, 1'b0, 1'b0);
    endtask

    task automatic idle_rand(input int n);
        logic [3:0] rr, rf;
        for (int i = 0; i < n; i++) begin
            rr = 4'($urandom);
            rf = ($urandom_range(0, 3) == 0) ? rr : 4'($urandom);
            push(rr, rf, 1'b0, $urandom_range(0, 7) == 0);
        end
    endtask

    // er_idx counts bytes from the first preamble byte; -1 for a clean frame.
    task automatic frame(input int npre, input logic [7:0] sfd, input int len, input int er_idx, input bit rnd);
        int idx = 0;
        for (int i = 0; i < npre; i++) begin
            push_byte(8'h55, idx == er_idx);
            idx++;
        end
        push_byte(sfd, idx == er_idx);
        idx++;
        for (int k = 0; k < len; k++) begin
            push_byte(rnd ? 8'($urandom) : 8'(k + 1), idx == er_idx);
            idx++;
        end
    endtask

    task automatic add_reset();
        s_rst[n_stim]     = 1'b1;
        s_rel[n_stim + 2] = 1'b1;
        idle_fix(3, 4'h0, 4'h0);
    endtask

    task automatic checkpoint(input int lag, input int ok, input int err, input int beats, input int st);
        cps.push_back('{n_stim + lag, ok, err, beats, st});
    endtask

    // One dv run from cycle s up to (not including) the first dv-low cycle e.
    task automatic model_run(input int s, input int e);
        int n, j, m, l, cyc;
        bit anyer;
        n = e - s;
        if (sbyte(s) != 8'h55) return;
        j = 1;
        while (j < n && !ser(s + j) && sbyte(s + j) == 8'h55) j++;
        if (j >= n) return;
        if (ser(s + j) || sbyte(s + j) != 8'hD5) return;
        if (((j < 7) ? j : 7) < MIN_PRE) return;
        m = n - j - 1;
        if (m == 0) begin
            err_inc[e + 2]++;
            return;
        end
        l = (m < MAX_LEN) ? m : MAX_LEN;
        anyer = 1'b0;
        for (int k = 0; k < m; k++) anyer |= ser(s + j + 1 + k);
        // Payload byte k leaves once byte k+1 (or the end) has passed two register stages.
        for (int k = 0; k < l; k++) begin
            cyc = s + j + k + 4;
            e_vld[cyc] = 1'b1;
            e_dat[cyc] = sbyte(s + j + 1 + k);
            if (k == l - 1) begin
                e_last[cyc] = 1'b1;
                e_user[cyc] = (m > MAX_LEN) || anyer;
                if (e_user[cyc]) err_inc[cyc]++;
                else ok_inc[cyc]++;
            end
        end
    endtask

    task automatic build_model();
        int c, e;
        c = 0;
        while (c < n_stim) begin
            if (!s_cr[c]) begin
                c++;
            end else begin
                e = c;
                while (e < n_stim && s_cr[e]) e++;
                model_run(c, e);
                c = e;
            end
        end
        for (int r = 0; r < n_stim; r++) begin
            if (s_rst[r]) begin
                for (int d = 1; d <= 2; d++) begin
                    e_vld[r + d] = 1'b0;
                    e_last[r + d] = 1'b0;
                    e_user[r + d] = 1'b0;
                    ok_inc[r + d] = 0;
                    err_inc[r + d] = 0;
                    rst_win[r + d] = 1'b1;
                end
                no_qual[r] = 1'b1;
                no_qual[r + 1] = 1'b1;
            end
        end
        for (int k = 0; k < n_stim + 4; k++) begin
            if (rst_win[k]) begin
                e_ok[k]  = '0;
                e_err[k] = '0;
                e_st[k]  = 4'h0;
            end else begin
                e_ok[k]  = ((k > 0) ? e_ok[k - 1] : '0) + CW'(ok_inc[k]);
                e_err[k] = ((k > 0) ? e_err[k - 1] : '0) + CW'(err_inc[k]);
                if (k >= 2 && !no_qual[k - 2] && !s_cr[k - 2] && !s_cf[k - 2] && s_rr[k - 2] == s_rf[k - 2])
                    e_st[k] = s_rr[k - 2];
                else
                    e_st[k] = (k > 0) ? e_st[k - 1] : 4'h0;
            end
        end
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, c, act, req);
        end
    endtask

    int cp_i  = 0;
    int beats = 0;

    task automatic compare_cycle(input int c);
        chk("tvalid", c, 32'(axis.tvalid), 32'(e_vld[c]));
        chk("tlast", c, 32'(axis.tlast), 32'(e_last[c]));
        chk("tuser", c, 32'(axis.tuser), 32'(e_user[c]));
        if (e_vld[c]) chk("tdata", c, 32'(axis.tdata), 32'(e_dat[c]));
        chk("frame_ok_cnt", c, frame_ok_cnt, e_ok[c]);
        chk("frame_err_cnt", c, frame_err_cnt, e_err[c]);
        chk("link_status", c, 32'({full_duplex, link_speed, link_up}), 32'(e_st[c]));
        if (axis.tvalid === 1'b1) beats++;
        if (cp_i < cps.size() && cps[cp_i].cyc == c) begin
            chk("cp_ok_cnt", c, frame_ok_cnt, 32'(cps[cp_i].ok));
            chk("cp_err_cnt", c, frame_err_cnt, 32'(cps[cp_i].err));
            if (cps[cp_i].beats >= 0) chk("cp_beats", c, 32'(beats), 32'(cps[cp_i].beats));
            if (cps[cp_i].st >= 0) chk("cp_status", c, 32'({full_duplex, link_speed, link_up}), 32'(cps[cp_i].st));
            beats = 0;
            cp_i++;
        end
    endtask

    initial begin
        int npre, len, eri;
        logic [7:0] sfd;
        for (int i = 0; i < N; i++) begin
            s_rr[i] = 4'h0;
            s_rf[i] = 4'h0;
        end

        idle_fix(4, 4'h0, 4'h0);
        frame(7, 8'hD5, 64, -1, 1'b0);
        idle_rand(12);
        checkpoint(0, 1, 0, 64, -1);
        frame(7, 8'hD5, 64, 7 + 1 + 9, 1'b0);
        idle_rand(12);
        checkpoint(0, 1, 1, 64, -1);
        frame(1, 8'hD5, 0, -1, 1'b0);
        idle_rand(8);
        checkpoint(0, 1, 1, 0, -1);
        frame(7, 8'hD5, 64, -1, 1'b1);
        idle_rand(12);
        checkpoint(0, 2, 1, 64, -1);
        frame(7, 8'hD5, MAX_LEN + 5, -1, 1'b1);
        idle_rand(12);
        checkpoint(0, 2, 2, MAX_LEN, -1);
        idle_fix(3, 4'hD, 4'hD);
        idle_fix(6, 4'h3, 4'hC);
        checkpoint(0, 2, 2, 0, 13);
        frame(7, 8'hD5, 64, -1, 1'b1);
        idle_fix(1, 4'h0, 4'h0);
        frame(7, 8'hD5, 64, -1, 1'b1);
        idle_fix(1, 4'h0, 4'h0);
        checkpoint(2, 4, 2, 128, -1);
        frame(7, 8'hD5, 30, -1, 1'b1);
        add_reset();
        idle_rand(6);
        checkpoint(0, 0, 0, -1, -1);
        frame(7, 8'hD5, 64, -1, 1'b1);
        idle_rand(12);
        checkpoint(0, 1, 0, 64, -1);
        frame(2, 8'hD5, 20, -1, 1'b1);
        idle_rand(6);
        checkpoint(0, 2, 0, 20, -1);
        for (int f = 0; f < 25; f++) begin
            npre = $urandom_range(0, 8);
            sfd  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hD5;
            len  = $urandom_range(0, 90);
            eri  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, npre + len) : -1;
            frame(npre, sfd, len, eri, 1'b1);
            idle_rand($urandom_range(1, 6));
        end
        idle_rand(10);

        build_model();

        repeat (3) @(posedge rx_clk);
        #1 sys_rst_n = 1'b1;
        for (int c = 0; c < n_stim + 4; c++) begin
            @(posedge rx_clk);
            #1;
            compare_cycle(c);
            if (c < n_stim) begin
                rxd_rise   = s_rr[c];
                rxd_fall   = s_rf[c];
                rxctl_rise = s_cr[c];
                rxctl_fall = s_cf[c];
            end else begin
                rxd_rise   = 4'h0;
                rxd_fall   = 4'h0;
                rxctl_rise = 1'b0;
                rxctl_fall = 1'b0;
            end
            if (s_rst[c]) sys_rst_n = 1'b0;
            if (s_rel[c]) sys_rst_n = 1'b1;
        end
        chk("checkpoints_reached", n_stim, 32'(cp_i), 32'(cps.size()));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgmii_rx_frame.md
Name: rgmii_rx_frame

Overview:
- Consumes RGMII receive data after input delay and IDDR capture (SAME_EDGE_PIPELINED, 1000 Mb/s only).
- Rebuilds bytes and decodes RX_CTL into data-valid and error.
- Strips preamble and SFD, then emits each frame as a byte-wide AXI-stream with tlast/tuser.
- Also decodes RGMII in-band link status and keeps good/bad frame counters; feeds the MAC rx path.

Parameters:
MIN_PREAMBLE, 2, minimum number of 0x55 bytes required before SFD (1-7)
MAX_LEN, 1518, maximum payload bytes after SFD; byte MAX_LEN+1 aborts the frame
CNT_WIDTH, 32, width of the statistics counters

Ports:
rx_clk  in  1  RGMII rx clock from the BUFG; all logic on its rising edge
sys_rst_n  in  1  asynchronous active-low reset
rxd_rise  in  4  nibble captured on the rising edge (byte bits 3:0)
rxd_fall  in  4  nibble captured on the falling edge (byte bits 7:4)
rxctl_rise  in  1  RX_CTL on the rising edge (rx_dv)
rxctl_fall  in  1  RX_CTL on the falling edge (rx_dv XOR rx_er)
m_axis_tdata  out  8  frame byte
m_axis_tvalid  out  1  byte valid; no backpressure, one cycle per byte
m_axis_tlast  out  1  last byte of frame
m_axis_tuser  out  1  frame bad; valid only with tlast
link_up  out  1  in-band link status
link_speed  out  2  in-band speed: 00=10M, 01=100M, 10=1000M
full_duplex  out  1  in-band duplex
frame_ok_cnt  out  CNT_WIDTH  frames ended with tuser=0
frame_err_cnt  out  CNT_WIDTH  frames ended with tuser=1, plus runts

Behaviour:
- Reset: all outputs 0, FSM in IDLE, hold register empty. Reset is asynchronous and can land mid-frame; the partial frame is discarded with no tlast emitted.
- Stage 0, registered:
  - byte_r = {rxd_fall, rxd_rise}
  - dv_r = rxctl_rise
  - er_r = rxctl_rise ^ rxctl_fall
- In-band status:
  - Updates when rxctl_rise=0, rxctl_fall=0 and rxd_rise==rxd_fall.
  - link_up=byte_r[0], link_speed=byte_r[2:1], full_duplex=byte_r[3].
  - Otherwise the status outputs hold. Status is never updated while dv_r=1.
- FSM, evaluated on byte_r/dv_r/er_r:
  - IDLE: dv_r and byte_r=0x55 -> PREAMBLE, pcnt=1. dv_r with any other byte -> DROP.
  - PREAMBLE:
    - 0x55 -> pcnt+1, saturating at 7.
    - 0xD5 with pcnt>=MIN_PREAMBLE -> PAYLOAD, len=0, err_seen=0.
    - 0xD5 with a short preamble, any other byte, or er_r -> DROP.
    - dv_r=0 -> IDLE.
    - Nothing is emitted and no counter changes in this state.
  - PAYLOAD:
    - Each dv_r byte goes into the one-byte hold register. If hold is full, the old byte is emitted first (tvalid=1, tlast=0).
    - len increments per byte; err_seen |= er_r.
    - dv_r=0: if hold is full, emit it with tlast=1 and tuser=err_seen. Then -> IDLE.
    - dv_r=0 with hold empty (SFD then end): emit nothing, frame_err_cnt+1, -> IDLE.
    - len reaching MAX_LEN+1: emit the held byte with tlast=1, tuser=1, then -> DROP.
  - DROP: ignore all bytes until dv_r=0, then -> IDLE.
- Simultaneous events: dv_r=0 in the same cycle a status update is eligible is legal; both happen.
- Back-to-back frames with a single dv_r=0 cycle between them are supported: IDLE is re-entered on that cycle.
- Outputs are registered.
- Latency:
  - A non-final byte appears on m_axis 2 cycles after the pins edge of the following byte.
  - The final byte appears 2 cycles after the first dv-low pins edge.
- tvalid pulses are never contiguous beyond frame length; tlast and tuser are 0 whenever tvalid=0.
- Counters increment the cycle tlast is emitted and wrap at 2^CNT_WIDTH.

Decomposition:
- Package eth_rx_pkg holds:
  - enum rx_state_t {IDLE, PREAMBLE, PAYLOAD, DROP}
  - localparams PREAMBLE_BYTE=8'h55 and SFD_BYTE=8'hD5
  - enum link_speed_t
- Sub-module rgmii_rx_decode owns stage 0 (byte/dv/er registers) and the in-band status decode.
- rgmii_rx_frame keeps the FSM, hold register, AXI output and counters.

Test Plan:
- 7x0x55, 0xD5, payload 0x01..0x40 (64 B), dv clean -> 64 tvalid beats with data 0x01..0x40; tlast on 0x40; tuser=0; frame_ok_cnt=1.
- Same frame with er asserted on payload byte 10 -> 64 beats, tuser=1 on the last beat, frame_err_cnt=1.
- 1x0x55 then 0xD5 with MIN_PREAMBLE=2 -> no tvalid, both counters unchanged. Next 7x0x55 frame is received normally.
- Payload of MAX_LEN+5 bytes -> MAX_LEN beats, last beat tlast=1 with tuser=1, frame_err_cnt+1, remainder dropped.
- Idle with rxd_rise=rxd_fall=4'hD -> link_up=1, link_speed=2'b10, full_duplex=1. Mismatched nibbles afterwards -> status holds.
- Two back-to-back 64 B frames with 1 idle cycle between them, plus sys_rst_n pulsed mid-third-frame -> 2 ok frames, no tlast for the third, counters reset to 0.
